// File: rtl/decoder38_pkg.sv
// Shared types and helpers for the decoder38_scan digit-select block.
// Holds the FSM state encoding, select width and the one-hot decode helper.
package decoder38_pkg;

  localparam int SEL_W = 8;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  function automatic logic [SEL_W-1:0] onehot8(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

endpackage

// File: rtl/decoder38_scan_prescaler.sv
// scan_prescaler: counts 0..CLK_DIV-1 while running; oStep is a combinational pulse at CLK_DIV-1.
// Latency: oStep is asserted during the last count cycle; iClr wins over iRun; the count is frozen when idle.
module scan_prescaler #(
  parameter int CLK_DIV = 100000
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iClr,
  input  logic iRun,
  output logic oStep
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign oStep  = iRun && w_last;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_cnt <= '0;
    end else if (iClr) begin
      r_cnt <= '0;
    end else if (iRun) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/decoder38_scan.sv
// decoder38_scan: registered 3-to-8 one-hot digit-select decoder with a built-in scan sequencer.
// Latency is 1 cycle; there is no backpressure. Defining DECODER38_BLANK_EN inserts one blank cycle on each scan step.
import decoder38_pkg::*;

module decoder38_scan #(
  parameter int CLK_DIV = 100000
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iEn,
  input  logic             iMode,
  input  logic             iValid,
  input  logic [2:0]       iData,
  output logic [SEL_W-1:0] oData,
  output logic [2:0]       oIdx,
  output logic             oValid,
  output logic             oWrap
);

  state_t           r_state;
  state_t           w_nxt;
  logic [SEL_W-1:0] r_data;
  logic [2:0]       r_idx;
  logic             r_valid;
  logic             r_wrap;
  logic             r_blank;
  logic             w_entry;
  logic             w_run;
  logic             w_step;

  always_comb begin
    w_nxt = OFF;
    if (iEn) begin
      w_nxt = iMode ? SCAN : DIRECT;
    end
  end

  // Entering SCAN restarts the prescaler; it only advances while SCAN is held.
  assign w_entry = (w_nxt == SCAN) && (r_state != SCAN);
  assign w_run   = (w_nxt == SCAN) && (r_state == SCAN);

  scan_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .iClr  (w_entry),
    .iRun  (w_run),
    .oStep (w_step)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= OFF;
      r_data  <= '0;
      r_idx   <= 3'd0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_blank <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_wrap  <= 1'b0;
      r_blank <= 1'b0;
      case (w_nxt)
        DIRECT: begin
          if (iValid) begin
            r_data  <= onehot8(iData);
            r_idx   <= iData;
            r_valid <= 1'b1;
          end else if (r_state != DIRECT) begin
            r_data  <= '0;
            r_valid <= 1'b0;
          end
        end
        SCAN: begin
          if (w_entry) begin
            r_idx   <= 3'd0;
            r_data  <= onehot8(3'd0);
            r_valid <= 1'b1;
          end else if (w_step) begin
            r_idx  <= r_idx + 3'd1;
            r_wrap <= (r_idx == 3'd7);
`ifdef DECODER38_BLANK_EN
            r_data  <= '0;
            r_valid <= 1'b0;
            r_blank <= 1'b1;
`else
            r_data  <= onehot8(r_idx + 3'd1);
            r_valid <= 1'b1;
`endif
          end else if (r_blank) begin
            // Light the digit whose index was latched on the blank cycle.
            r_data  <= onehot8(r_idx);
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign oData  = r_data;
  assign oIdx   = r_idx;
  assign oValid = r_valid;
  assign oWrap  = r_wrap;

endmodule

// File: tb/tb_decoder38_scan.sv
// Directed bench for decoder38_scan with CLK_DIV=4; DECODER38_BLANK_EN selects blanked scan expectations.
module tb_decoder38_scan;

  logic       iClk;
  logic       iRst_n;
  logic       iEn;
  logic       iMode;
  logic       iValid;
  logic [2:0] iData;
  logic [7:0] oData;
  logic [2:0] oIdx;
  logic       oValid;
  logic       oWrap;

  int checks = 0;
  int errors = 0;

  decoder38_scan #(.CLK_DIV(4)) dut (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .iEn   (iEn),
    .iMode (iMode),
    .iValid(iValid),
    .iData (iData),
    .oData (oData),
    .oIdx  (oIdx),
    .oValid(oValid),
    .oWrap (oWrap)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [12:0] exp);
    logic [12:0] obs;
    obs = {oData, oIdx, oValid, oWrap};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s data/idx/valid/wrap observed=%h/%0d/%b/%b expected=%h/%0d/%b/%b",
             tag, obs[12:5], obs[4:2], obs[1], obs[0], exp[12:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [12:0] pack(input logic [7:0] d, input logic [2:0] i,
                                       input logic v, input logic w);
    return {d, i, v, w};
  endfunction

  // Expected outputs k cycles after entering SCAN (k=0 is the entry edge).
  function automatic logic [12:0] scan_exp(input int k);
    int         idx;
    logic [7:0] d;
    logic       v;
    logic       w;
    idx = (k / 4) % 8;
    d   = 8'h01 << idx;
    v   = 1'b1;
    w   = (k > 0) && (k % 4 == 0) && (idx == 0);
`ifdef DECODER38_BLANK_EN
    if (k > 0 && k % 4 == 0) begin
      d = 8'h00;
      v = 1'b0;
    end
`endif
    return {d, 3'(idx), v, w};
  endfunction

  initial begin
    iRst_n = 1'b0;
    iEn    = 1'b0;
    iMode  = 1'b0;
    iValid = 1'b0;
    iData  = 3'd0;

    // Reset held with random inputs.
    for (int r = 0; r < 2; r++) begin
      iEn    = 1'($urandom_range(0, 1));
      iMode  = 1'($urandom_range(0, 1));
      iValid = 1'($urandom_range(0, 1));
      iData  = 3'($urandom_range(0, 7));
      step();
      check("reset_hold", pack(8'h00, 3'd0, 1'b0, 1'b0));
    end

    // Release into DIRECT with no valid: blank until first iValid.
    iEn = 1'b1; iMode = 1'b0; iValid = 1'b0; iData = 3'd0;
    iRst_n = 1'b1;
    step();
    check("direct_entry", pack(8'h00, 3'd0, 1'b0, 1'b0));

    // Direct sweep, one iValid pulse every 40 ns.
    for (int i = 0; i < 8; i++) begin
      iValid = 1'b1;
      iData  = 3'(i);
      step();
      check("direct_sweep", pack(8'h01 << i, 3'(i), 1'b1, 1'b0));
      iValid = 1'b0;
      for (int h = 0; h < 3; h++) step();
    end
    iData = 3'd3;
    step();
    check("direct_hold", pack(8'h80, 3'd7, 1'b1, 1'b0));
    iData = 3'd1;
    step();
    check("direct_hold2", pack(8'h80, 3'd7, 1'b1, 1'b0));

    // Scan: a little over one frame, including the 7->0 wrap.
    iMode = 1'b1;
    for (int k = 0; k <= 53; k++) begin
      step();
      check("scan", scan_exp(k));
    end

    // Enable gating during index 5, then restart at 0.
    iEn = 1'b0;
    step();
    check("en_off", pack(8'h00, 3'd5, 1'b0, 1'b0));
    step();
    step();
    check("en_off_frozen", pack(8'h00, 3'd5, 1'b0, 1'b0));
    iEn = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      step();
      check("scan_restart", scan_exp(k));
    end

    // SCAN -> DIRECT with iValid on the switch cycle, then back to SCAN.
    iMode = 1'b0; iValid = 1'b1; iData = 3'd6;
    step();
    check("mode_direct", pack(8'h40, 3'd6, 1'b1, 1'b0));
    iValid = 1'b0; iData = 3'd2;
    step();
    check("mode_direct_hold", pack(8'h40, 3'd6, 1'b1, 1'b0));
    iMode = 1'b1; iValid = 1'b1; iData = 3'd5;
    for (int k = 0; k <= 5; k++) begin
      step();
      check("mode_rescan", scan_exp(k));
    end

    // Reset asserted mid-scan clears outputs without waiting for an edge.
    #2;
    iRst_n = 1'b0;
    #1;
    check("reset_mid_scan", pack(8'h00, 3'd0, 1'b0, 1'b0));
    step();
    check("reset_mid_hold", pack(8'h00, 3'd0, 1'b0, 1'b0));
    iRst_n = 1'b1;
    step();
    check("reset_release_scan", scan_exp(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder38_scan.md
# decoder38_scan

Registered 3-to-8 one-hot decoder with a built-in scan sequencer, the inverse of the team's 8-to-3 encoder. It drives the eight digit-select lines of the board's multiplexed 7-segment display. In direct mode it decodes a supplied 3-bit index. In scan mode it steps the index through 0..7 on a programmable prescaler.

## Interface
- CLK_DIV, default 100000: clock cycles each digit stays selected in scan mode; legal range ≥2.
- iClk  input  1  system clock; all state updates on its rising edge.
- iRst_n  input  1  asynchronous, active-low reset.
- iEn  input  1  block enable; low blanks all outputs and freezes the sequencer.
- iMode  input  1  0 = direct decode, 1 = auto scan.
- iValid  input  1  direct mode: iData is sampled on this cycle.
- iData  input  3  direct-mode index to decode.
- oData  output  8  one-hot select, active-high; bit n high selects digit n.
- oIdx  output  3  index currently encoded on oData.
- oValid  output  1  high when oData holds a valid one-hot code.
- oWrap  output  1  one-cycle pulse when the scan index wraps from 7 to 0.

## Operation
- The FSM has three states: OFF, DIRECT, SCAN. The next state is evaluated every cycle:
  - iEn=0 → OFF.
  - iEn=1, iMode=0 → DIRECT.
  - iEn=1, iMode=1 → SCAN.
- OFF:
  - oData=8'h00, oValid=0, oWrap=0.
  - oIdx holds its last value.
  - The prescaler and the scan index are frozen.
- DIRECT:
  - When iValid=1, the next cycle gives oData = 8'h01 << iData, oIdx = iData, oValid=1.
  - When iValid=0, all outputs hold.
  - Entering DIRECT from OFF or SCAN: oValid=0 and oData=8'h00 until the first iValid.
- SCAN:
  - On entry from any other state, the prescaler clears to 0, the index is set to 0, and the next cycle gives oData=8'h01, oIdx=0, oValid=1.
  - The prescaler counts 0..CLK_DIV-1.
  - When the prescaler reaches CLK_DIV-1 it returns to 0 and the index increments modulo 8. oData and oIdx follow on the same edge.
  - On the 7→0 step, oWrap=1 for exactly that cycle.
  - iValid and iData are ignored.
- Prescaler width is $clog2(CLK_DIV). Index arithmetic is 3-bit unsigned and wraps naturally.
- oData is always either all-zero or exactly one-hot. It is never multi-hot.

## Timing
- Reset (iRst_n=0, asynchronous, takes effect immediately):
  - State OFF.
  - oData=8'h00, oIdx=3'd0, oValid=0, oWrap=0.
  - Prescaler and index cleared.
- Reset release: the first active edge evaluates the state from iEn/iMode. Reset asserted mid-scan aborts the scan immediately with no partial step.
- Direct decode latency: 1 cycle from the iValid edge to oData.
- Scan entry latency: 1 cycle from the iMode/iEn change to oData=8'h01.
- Scan period: each digit is held for exactly CLK_DIV cycles. A full frame is 8·CLK_DIV cycles.
- iEn falling: the next cycle shows oData=0. Re-enabling into SCAN restarts from index 0; the scan does not resume.
- iMode toggling 1→0→1 restarts the scan at index 0.
- iValid asserted on the same cycle as a switch into DIRECT: that iData is decoded.

## Configuration
- DECODER38_BLANK_EN, when defined: in SCAN, each index step first drives oData=8'h00 and oValid=0 for one cycle, then the new one-hot code.
  - This suppresses display ghosting.
  - oIdx updates on the blank cycle.
  - oWrap pulses on the blank cycle of the 7→0 step.
  - Per-digit period stays CLK_DIV cycles: 1 blank cycle plus CLK_DIV-1 lit cycles.
  - The entry cycle is not blanked.
  - DIRECT is unaffected.
- When not defined: index steps switch directly between one-hot codes with no gap.

## Structure
- Package decoder38_pkg holds:
  - the state enum (OFF, DIRECT, SCAN);
  - the constant SEL_W=8;
  - function onehot8(idx) returning 8'h01 << idx.
- One sub-module, scan_prescaler:
  - parameter CLK_DIV;
  - inputs iClk, iRst_n, iClr, iRun;
  - output oStep, a one-cycle pulse at count CLK_DIV-1.
- The FSM and output registers live in decoder38_scan.

## Test plan
All scenarios use CLK_DIV=4.
- Reset: hold iRst_n=0 with random inputs → oData=8'h00, oIdx=0, oValid=0, oWrap=0. Assert reset mid-scan → outputs clear immediately.
- Direct sweep: iEn=1, iMode=0, iValid pulsed with iData=0..7 every 40 ns → one cycle later oData=01,02,04,08,10,20,40,80 with matching oIdx. With iValid=0 and iData changing → oData holds.
- Scan: iEn=1, iMode=1 → oData=01 for 4 cycles, then 02, …, 80, then 01 again. oWrap is high only on the 80→01 cycle. Frame is 32 cycles.
- Enable gating: drop iEn during oIdx=5 → oData=00 next cycle. Raise iEn → restart at oData=01.
- Mode switch: go SCAN→DIRECT with iValid=1, iData=6 on the same cycle → oData=40. Go back to SCAN → oData=01.
- With DECODER38_BLANK_EN defined: SCAN shows a 1-cycle 8'h00 with oValid=0 between codes. Each code is lit 3 cycles. The entry cycle is not blanked.
